// File: rtl/prog_mem_sequencer.sv
// Shares the MC14500B program memory port between the UART loader and CPU fetch.
// Optional load idle timeout is enabled by defining PROG_LOAD_TIMEOUT_EN.
module prog_mem_sequencer #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 12,
  parameter int RESET_CYCLES = 4,
  parameter int LOAD_TIMEOUT = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ld_address,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_write,
  input  logic                  ld_done,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  output logic [DATA_WIDTH-1:0] cpu_instr,
  output logic                  cpu_hold,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  loading,
  output logic [ADDR_WIDTH:0]   write_count,
  output logic                  load_error
);

  typedef enum logic [1:0] {HALT, LOAD, RELEASE, RUN} state_t;

  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam logic [RCW-1:0] REL_LOAD = RCW'(RESET_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_next;
  logic [RCW-1:0]        rel_cnt;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  fetch_valid;
  logic                  timeout;

`ifdef PROG_LOAD_TIMEOUT_EN
  localparam int TOW = $clog2(LOAD_TIMEOUT + 1);
  logic [TOW-1:0] idle_cnt;

  assign timeout = (state == LOAD) && !ld_write && !ld_done &&
                   (idle_cnt == TOW'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt   <= '0;
      load_error <= 1'b0;
    end else begin
      if (state == LOAD && !ld_write && !ld_done)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;
      if (ld_write)
        load_error <= 1'b0;
      else if (timeout)
        load_error <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (LOAD_TIMEOUT > 0);
  assign timeout    = 1'b0;
  assign load_error = 1'b0;
`endif

  // ld_done outranks ld_write so a simultaneous pair still lands in RELEASE.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (timeout) state_next = HALT;
      RELEASE: if (rel_cnt == '0) state_next = RUN;
      default: state_next = state;
    endcase
    if (ld_done)
      state_next = RELEASE;
    else if (ld_write)
      state_next = LOAD;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HALT;
      rel_cnt     <= '0;
      cpu_hold    <= 1'b1;
      cpu_reset   <= 1'b1;
      loading     <= 1'b0;
      mem_we      <= 1'b0;
      addr_r      <= '0;
      mem_wdata   <= '0;
      write_count <= '0;
      fetch_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_hold  <= (state_next != RUN);
      cpu_reset <= (state_next == HALT) || (state_next == RELEASE);
      loading   <= (state_next == LOAD);

      if (state_next == RELEASE && (state != RELEASE || ld_done))
        rel_cnt <= REL_LOAD;
      else if (state == RELEASE && rel_cnt != '0)
        rel_cnt <= rel_cnt - 1'b1;

      mem_we <= ld_write;
      if (ld_write) begin
        addr_r    <= ld_address;
        mem_wdata <= ld_data;
        if (state != LOAD)
          write_count <= (ADDR_WIDTH + 1)'(1);
        else if (write_count != WC_MAX)
          write_count <= write_count + 1'b1;
      end

      fetch_valid <= (state == RUN) && !ld_write;
    end
  end

  assign mem_address = (state == RUN) ? cpu_address : addr_r;
  assign cpu_instr   = fetch_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_prog_mem_sequencer.sv
// Directed bench for prog_mem_sequencer with a behavioural synchronous RAM.
// Timeout checks compile in when PROG_LOAD_TIMEOUT_EN is defined.
module tb_prog_mem_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  ld_address;
  logic [11:0] ld_data;
  logic        ld_write;
  logic        ld_done;
  logic [7:0]  cpu_address;
  logic [11:0] cpu_instr;
  logic        cpu_hold;
  logic        cpu_reset;
  logic [7:0]  mem_address;
  logic [11:0] mem_wdata;
  logic        mem_we;
  logic [11:0] mem_rdata;
  logic        loading;
  logic [8:0]  write_count;
  logic        load_error;

  int tests  = 0;
  int errors = 0;

  logic [11:0] ram [256];

  prog_mem_sequencer #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(12),
    .RESET_CYCLES(4),
    .LOAD_TIMEOUT(20)
  ) dut (
    .clock(clock), .reset(reset),
    .ld_address(ld_address), .ld_data(ld_data),
    .ld_write(ld_write), .ld_done(ld_done),
    .cpu_address(cpu_address), .cpu_instr(cpu_instr),
    .cpu_hold(cpu_hold), .cpu_reset(cpu_reset),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .loading(loading),
    .write_count(write_count), .load_error(load_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) ram[mem_address] <= mem_wdata;
    mem_rdata <= ram[mem_address];
  end

  typedef struct {
    logic        w;
    logic        d;
    logic [7:0]  a;
    logic [11:0] dat;
    logic [7:0]  ca;
    logic        e_we;
    logic [7:0]  e_ma;
    logic [11:0] e_wd;
    logic        e_hold;
    logic        e_rst;
    logic        e_load;
    logic [11:0] e_instr;
    logic [8:0]  e_wc;
  } vec_t;

  vec_t vt [25];

  function automatic vec_t mk(logic w, logic d, logic [7:0] a, logic [11:0] dat,
                              logic [7:0] ca, logic we, logic [7:0] ma,
                              logic [11:0] wd, logic h, logic r, logic l,
                              logic [11:0] ins, logic [8:0] wc);
    vec_t v;
    v.w = w; v.d = d; v.a = a; v.dat = dat; v.ca = ca;
    v.e_we = we; v.e_ma = ma; v.e_wd = wd; v.e_hold = h; v.e_rst = r;
    v.e_load = l; v.e_instr = ins; v.e_wc = wc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    ld_write = 1'b0; ld_done = 1'b0; ld_address = '0; ld_data = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    cpu_address = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;

    // main load / release / run / reload scenario; expected values are after the edge
    vt[0]  = mk(1'b1,1'b0,8'd0,12'h1A0,8'd0, 1'b1,8'd0,12'h1A0,1'b1,1'b0,1'b1,12'h000,9'd1);
    vt[1]  = mk(1'b1,1'b0,8'd1,12'h2B1,8'd0, 1'b1,8'd1,12'h2B1,1'b1,1'b0,1'b1,12'h000,9'd2);
    vt[2]  = mk(1'b1,1'b0,8'd2,12'h3C2,8'd0, 1'b1,8'd2,12'h3C2,1'b1,1'b0,1'b1,12'h000,9'd3);
    vt[3]  = mk(1'b0,1'b1,8'd0,12'h000,8'd0, 1'b0,8'd2,12'h3C2,1'b1,1'b1,1'b0,12'h000,9'd3);
    vt[4]  = mk(1'b0,1'b0,8'd0,12'h000,8'd0, 1'b0,8'd2,12'h3C2,1'b1,1'b1,1'b0,12'h000,9'd3);
    vt[5]  = vt[4];
    vt[6]  = vt[4];
    vt[7]  = mk(1'b0,1'b0,8'd0,12'h000,8'd0, 1'b0,8'd0,12'h3C2,1'b0,1'b0,1'b0,12'h000,9'd3);
    vt[8]  = mk(1'b0,1'b0,8'd0,12'h000,8'd0, 1'b0,8'd0,12'h3C2,1'b0,1'b0,1'b0,12'h1A0,9'd3);
    vt[9]  = mk(1'b0,1'b0,8'd0,12'h000,8'd1, 1'b0,8'd1,12'h3C2,1'b0,1'b0,1'b0,12'h2B1,9'd3);
    vt[10] = mk(1'b0,1'b0,8'd0,12'h000,8'd2, 1'b0,8'd2,12'h3C2,1'b0,1'b0,1'b0,12'h3C2,9'd3);
    vt[11] = mk(1'b1,1'b0,8'd5,12'hABC,8'd0, 1'b1,8'd5,12'hABC,1'b1,1'b0,1'b1,12'h000,9'd1);
    vt[12] = mk(1'b0,1'b1,8'd0,12'h000,8'd0, 1'b0,8'd5,12'hABC,1'b1,1'b1,1'b0,12'h000,9'd1);
    vt[13] = mk(1'b1,1'b0,8'd6,12'h155,8'd0, 1'b1,8'd6,12'h155,1'b1,1'b0,1'b1,12'h000,9'd1);
    vt[14] = mk(1'b1,1'b1,8'd7,12'h2AA,8'd0, 1'b1,8'd7,12'h2AA,1'b1,1'b1,1'b0,12'h000,9'd2);
    vt[15] = mk(1'b0,1'b0,8'd0,12'h000,8'd0, 1'b0,8'd7,12'h2AA,1'b1,1'b1,1'b0,12'h000,9'd2);
    vt[16] = mk(1'b0,1'b1,8'd0,12'h000,8'd0, 1'b0,8'd7,12'h2AA,1'b1,1'b1,1'b0,12'h000,9'd2);
    vt[17] = vt[15];
    vt[18] = vt[15];
    vt[19] = vt[15];
    vt[20] = mk(1'b0,1'b0,8'd0,12'h000,8'd7, 1'b0,8'd7,12'h2AA,1'b0,1'b0,1'b0,12'h000,9'd2);
    vt[21] = mk(1'b0,1'b0,8'd0,12'h000,8'd7, 1'b0,8'd7,12'h2AA,1'b0,1'b0,1'b0,12'h2AA,9'd2);
    vt[22] = mk(1'b0,1'b0,8'd0,12'h000,8'd5, 1'b0,8'd5,12'h2AA,1'b0,1'b0,1'b0,12'hABC,9'd2);
    vt[23] = mk(1'b0,1'b1,8'd0,12'h000,8'd0, 1'b0,8'd7,12'h2AA,1'b1,1'b1,1'b0,12'h1A0,9'd2);
    vt[24] = mk(1'b0,1'b0,8'd0,12'h000,8'd0, 1'b0,8'd7,12'h2AA,1'b1,1'b1,1'b0,12'h000,9'd2);

    do_reset();
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_instr", 32'(cpu_instr), 32'd0);
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_wc", 32'(write_count), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_hold", 32'(cpu_hold), 32'd1);
      chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_instr", 32'(cpu_instr), 32'd0);
    end

    for (int i = 0; i < 25; i++) begin
      ld_write = vt[i].w; ld_done = vt[i].d;
      ld_address = vt[i].a; ld_data = vt[i].dat; cpu_address = vt[i].ca;
      tick();
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(mem_address), 32'(vt[i].e_ma));
      chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vt[i].e_wd));
      chk($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(vt[i].e_hold));
      chk($sformatf("v%0d_cpu_reset", i), 32'(cpu_reset), 32'(vt[i].e_rst));
      chk($sformatf("v%0d_loading", i), 32'(loading), 32'(vt[i].e_load));
      chk($sformatf("v%0d_instr", i), 32'(cpu_instr), 32'(vt[i].e_instr));
      chk($sformatf("v%0d_wc", i), 32'(write_count), 32'(vt[i].e_wc));
    end
    chk("ram5", 32'(ram[5]), 32'h0ABC);
    chk("ram6", 32'(ram[6]), 32'h0155);

    // reset on the same edge as a write suppresses it
    idle_inputs();
    ld_write = 1'b1; ld_address = 8'd9; ld_data = 12'h777; reset = 1'b1;
    tick();
    reset = 1'b0; idle_inputs();
    chk("rstw_we", 32'(mem_we), 32'd0);
    chk("rstw_loading", 32'(loading), 32'd0);
    chk("rstw_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rstw_wc", 32'(write_count), 32'd0);
    tick();
    chk("rstw_ram", 32'(ram[9]), 32'd0);

    // write_count saturation
    for (int i = 0; i < 257; i++) begin
      ld_write = 1'b1; ld_address = i[7:0]; ld_data = 12'(i);
      tick();
      if (i == 0)   chk("sat_wc1", 32'(write_count), 32'd1);
      if (i == 255) chk("sat_wc256", 32'(write_count), 32'd256);
      if (i == 256) chk("sat_wc257", 32'(write_count), 32'd256);
    end
    idle_inputs();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    chk("sat_release", 32'(cpu_reset), 32'd1);
    chk("sat_wc_hold", 32'(write_count), 32'd256);

`ifdef PROG_LOAD_TIMEOUT_EN
    do_reset();
    ld_write = 1'b1; ld_address = 8'd3; ld_data = 12'h123;
    tick();
    idle_inputs();
    chk("to_loading", 32'(loading), 32'd1);
    repeat (19) tick();
    chk("to_still_loading", 32'(loading), 32'd1);
    chk("to_no_err_yet", 32'(load_error), 32'd0);
    tick();
    chk("to_halt_loading", 32'(loading), 32'd0);
    chk("to_halt_reset", 32'(cpu_reset), 32'd1);
    chk("to_halt_hold", 32'(cpu_hold), 32'd1);
    chk("to_err", 32'(load_error), 32'd1);
    repeat (3) tick();
    chk("to_err_sticky", 32'(load_error), 32'd1);
    ld_write = 1'b1; ld_address = 8'd4;
    tick();
    idle_inputs();
    chk("to_err_clear", 32'(load_error), 32'd0);
    chk("to_reload", 32'(loading), 32'd1);
    chk("to_wc", 32'(write_count), 32'd1);
`else
    do_reset();
    ld_write = 1'b1; ld_address = 8'd3; ld_data = 12'h123;
    tick();
    idle_inputs();
    repeat (30) tick();
    chk("nto_loading", 32'(loading), 32'd1);
    chk("nto_err", 32'(load_error), 32'd0);
    chk("nto_reset", 32'(cpu_reset), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
